// File: rtl/complete_arbiter_pkg.sv
// rtl/complete_arbiter_pkg.sv - completion message type and source indices
package complete_arbiter_pkg;

  typedef struct packed {
    logic [7:0]  dest_phys;
    logic [4:0]  dest_logic;
    logic [31:0] data;
  } wb_content_t;

  localparam int CONTENT_W = $bits(wb_content_t);

  // Non-writeback kinds reuse the same bits through raw
  typedef union packed {
    wb_content_t          wb;
    logic [CONTENT_W-1:0] raw;
  } content_t;

  typedef struct packed {
    logic [7:0] commit_id;
    logic       kind;
    content_t   content;
  } complete_msg_t;

  localparam int CPL_W = $bits(complete_msg_t);

  localparam int SRC_ALU  = 0;
  localparam int SRC_BU   = 1;
  localparam int SRC_FPU  = 2;
  localparam int SRC_UART = 3;

endpackage

// File: rtl/complete_arbiter_if.sv
// rtl/complete_arbiter_if.sv - sender side and completion bus Message handshakes
interface complete_arbiter_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0]                                 req_en;
  logic [N_SRC*complete_arbiter_pkg::CPL_W-1:0]     req_msg;
  logic [N_SRC-1:0]                                 req_reject;
  logic                                             cpl_en;
  complete_arbiter_pkg::complete_msg_t              cpl_msg;
  logic                                             cpl_reject;

  modport master (
    output req_en, req_msg, cpl_reject,
    input  req_reject, cpl_en, cpl_msg
  );

  modport slave (
    input  req_en, req_msg, cpl_reject,
    output req_reject, cpl_en, cpl_msg
  );
endinterface

// File: rtl/complete_arbiter_rr_picker.sv
// rtl/complete_arbiter_rr_picker.sv - combinational round-robin picker starting at ptr
module rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any
);
  logic [PTR_W-1:0] idx;

  // Scan from farthest to nearest so the nearest requester overwrites
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (req[idx]) grant = idx;
    end
  end
endmodule

// File: rtl/complete_arbiter.sv
// rtl/complete_arbiter.sv - round-robin arbiter onto the completion bus, one-entry output stage
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int CNT_W = 32
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 flash,
  complete_arbiter_if.slave    bus,
  output logic [CNT_W-1:0]     contention_cnt
);
  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic             out_valid;
  complete_msg_t    out_msg;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant;
  logic             any;
  logic             can_load;
  logic             take;
  logic             multi;
  complete_msg_t    src_msg [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign src_msg[i] = bus.req_msg[i*CPL_W +: CPL_W];
  end

  rr_picker #(.N(N_SRC), .PTR_W(PTR_W)) u_picker (
    .req   (bus.req_en),
    .ptr   (rr_ptr),
    .grant (grant),
    .any   (any)
  );

  assign can_load = ~out_valid | ~bus.cpl_reject;
  assign take     = can_load & any & ~flash;
  assign multi    = $countones(bus.req_en) > 1;

  always_comb begin
    bus.req_reject = '1;
    for (int i = 0; i < N_SRC; i++) begin
      if (take && grant == PTR_W'(i)) bus.req_reject[i] = 1'b0;
    end
  end

  assign bus.cpl_en  = out_valid & ~flash;
  assign bus.cpl_msg = out_msg;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      out_valid      <= 1'b0;
      out_msg        <= '0;
      rr_ptr         <= '0;
      contention_cnt <= '0;
    end else begin
      if (flash) begin
        out_valid <= 1'b0;
        rr_ptr    <= '0;
      end else if (can_load) begin
        out_valid <= any;
        if (any) begin
          out_msg <= src_msg[grant];
          rr_ptr  <= (grant == PTR_W'(N_SRC - 1)) ? '0 : grant + 1'b1;
        end
      end
      // Counts demand, not grants, so it keeps counting under backpressure
      if (!flash && multi && contention_cnt != {CNT_W{1'b1}})
        contention_cnt <= contention_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_complete_arbiter.sv
// tb/tb_complete_arbiter.sv - directed and random checks of complete_arbiter against a behavioural model
module tb_complete_arbiter;
  import complete_arbiter_pkg::*;

  localparam int N = 4;

  logic        clock = 1'b0;
  logic        nreset;
  logic        flash;
  logic [31:0] contention_cnt;
  logic [1:0]  contention_cnt_s;

  complete_arbiter_if #(.N_SRC(N)) bus ();
  complete_arbiter_if #(.N_SRC(N)) bus_s ();

  assign bus_s.req_en     = bus.req_en;
  assign bus_s.req_msg    = bus.req_msg;
  assign bus_s.cpl_reject = bus.cpl_reject;

  complete_arbiter #(.N_SRC(N), .CNT_W(32)) dut (
    .clock          (clock),
    .nreset         (nreset),
    .flash          (flash),
    .bus            (bus.slave),
    .contention_cnt (contention_cnt)
  );

  complete_arbiter #(.N_SRC(N), .CNT_W(2)) dut_s (
    .clock          (clock),
    .nreset         (nreset),
    .flash          (flash),
    .bus            (bus_s.slave),
    .contention_cnt (contention_cnt_s)
  );

  always #5 clock = ~clock;

  int            vectors = 0;
  int            fails   = 0;
  bit            m_valid;
  complete_msg_t m_msg;
  int            m_ptr;
  longint        m_cnt;
  int            m_cnt_s;
  complete_msg_t src [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] req);
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_msg   = '0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_cnt_s = 0;
  endtask

  // One clock cycle: drive at negedge, check settled outputs, advance the model at posedge
  task automatic cycle(input logic [N-1:0] req, input bit fl, input bit crej, output int granted);
    logic [N-1:0] exp_rej;
    bit           can_load;
    int           g;
    bit           take;
    bus.req_en     = req;
    flash          = fl;
    bus.cpl_reject = crej;
    for (int i = 0; i < N; i++) bus.req_msg[i*CPL_W +: CPL_W] = src[i];
    #1;
    can_load = !m_valid || !crej;
    g        = model_grant(req);
    take     = can_load && (g >= 0) && !fl;
    exp_rej  = '1;
    if (take) exp_rej[g] = 1'b0;
    chk("req_reject", 64'(bus.req_reject), 64'(exp_rej));
    chk("cpl_en", 64'(bus.cpl_en), 64'(m_valid && !fl));
    chk("cpl_msg", 64'(bus.cpl_msg), 64'(m_msg));
    chk("contention_cnt", 64'(contention_cnt), 64'(m_cnt));
    chk("contention_cnt_sat", 64'(contention_cnt_s), 64'(m_cnt_s));
    granted = take ? g : -1;
    @(posedge clock);
    if (fl) begin
      m_valid = 1'b0;
      m_ptr   = 0;
    end else if (can_load) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_msg = src[g];
        m_ptr = (g + 1) % N;
      end
    end
    if (!fl && $countones(req) >= 2) begin
      m_cnt++;
      if (m_cnt_s < 3) m_cnt_s++;
    end
    @(negedge clock);
  endtask

  initial begin
    int g;
    nreset         = 1'b0;
    flash          = 1'b0;
    bus.req_en     = '0;
    bus.req_msg    = '0;
    bus.cpl_reject = 1'b0;
    for (int i = 0; i < N; i++) begin
      src[i]                       = '0;
      src[i].commit_id             = 8'(10 + i);
      src[i].kind                  = 1'(i);
      src[i].content.wb.data       = 32'hA000 + 32'(i);
      src[i].content.wb.dest_logic = 5'(i + 1);
    end
    src[SRC_ALU].commit_id       = 8'd5;
    src[SRC_ALU].content.wb.data = 32'h1234;
    src[SRC_FPU].commit_id       = 8'd7;
    model_reset();
    repeat (2) @(negedge clock);
    chk("reset_reject", 64'(bus.req_reject), 64'hF);
    chk("reset_cpl_en", 64'(bus.cpl_en), 64'h0);
    chk("reset_cpl_msg", 64'(bus.cpl_msg), 64'h0);
    chk("reset_cnt", 64'(contention_cnt), 64'h0);
    nreset = 1'b1;

    // Single ALU request
    cycle(4'b0001, 1'b0, 1'b0, g);
    chk("single_grant", 64'(g), 64'(SRC_ALU));
    chk("single_cid", 64'(bus.cpl_msg.commit_id), 64'd5);
    chk("single_data", 64'(bus.cpl_msg.content.wb.data), 64'h1234);
    chk("single_ptr", 64'(dut.rr_ptr), 64'd1);
    cycle(4'b0000, 1'b0, 1'b0, g);

    // All four continuously, from a flushed pointer
    cycle(4'b0000, 1'b1, 1'b0, g);
    for (int c = 0; c < 8; c++) begin
      cycle(4'b1111, 1'b0, 1'b0, g);
      chk("rr_grant", 64'(g), 64'(c % N));
      chk("rr_cpl_en", 64'(bus.cpl_en), 64'h1);
    end
    chk("contention_8", 64'(contention_cnt), 64'd8);
    chk("contention_sat", 64'(contention_cnt_s), 64'd3);

    // Backpressure holds commit_id 7 while BU waits
    cycle(4'b0100, 1'b0, 1'b0, g);
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold_cid", 64'(bus.cpl_msg.commit_id), 64'd7);
      cycle(4'b0010, 1'b0, 1'b1, g);
      chk("bp_no_grant", 64'(g), -64'sd1);
    end
    cycle(4'b0010, 1'b0, 1'b0, g);
    chk("bp_release_grant", 64'(g), 64'(SRC_BU));
    chk("bp_release_msg", 64'(bus.cpl_msg), 64'(src[SRC_BU]));

    // Flash with a valid output and UART requesting
    cycle(4'b1000, 1'b1, 1'b0, g);
    chk("flash_no_grant", 64'(g), -64'sd1);
    chk("flash_ptr", 64'(dut.rr_ptr), 64'd0);
    flash      = 1'b0;
    bus.req_en = '0;
    #1;
    chk("flash_cleared", 64'(bus.cpl_en), 64'h0);

    // Pointer wrap from 3
    cycle(4'b0100, 1'b0, 1'b0, g);
    cycle(4'b0011, 1'b0, 1'b0, g);
    chk("wrap_grant0", 64'(g), 64'(SRC_ALU));
    chk("wrap_ptr", 64'(dut.rr_ptr), 64'd1);
    cycle(4'b0011, 1'b0, 1'b0, g);
    chk("wrap_grant1", 64'(g), 64'(SRC_BU));

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        src[i].commit_id   = 8'($urandom);
        src[i].kind        = 1'($urandom);
        src[i].content.raw = CONTENT_W'({$urandom, $urandom});
      end
      cycle(4'($urandom), ($urandom_range(15) == 0), ($urandom_range(2) == 0), g);
    end

    // Asynchronous reset while the bus is valid
    cycle(4'b0001, 1'b0, 1'b0, g);
    chk("areset_pre_en", 64'(bus.cpl_en), 64'h1);
    bus.req_en = '0;
    #2;
    nreset = 1'b0;
    #1;
    chk("areset_cpl_en", 64'(bus.cpl_en), 64'h0);
    chk("areset_reject", 64'(bus.req_reject), 64'hF);
    model_reset();
    @(negedge clock);
    nreset = 1'b1;
    chk("areset_cnt", 64'(contention_cnt), 64'h0);
    cycle(4'b1111, 1'b0, 1'b0, g);
    chk("areset_grant", 64'(g), 64'(SRC_ALU));
    cycle(4'b0000, 1'b0, 1'b0, g);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
